uart_hex_entry: RTL and testbench

//  Line editor between uart_in and hex_display/uart_queue. Consumes received

---
 rtl/uart_console_pkg.sv | 26 ++
 rtl/ascii_hex_decode.sv | 32 +++
 rtl/uart_hex_entry.sv | 160 ++++++++++++++++
 tb/tb_uart_hex_entry.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_console_pkg.sv
// Shared definitions for the console line editor: ASCII control codes,
// the byte classes produced by the decoder and the entry-state encoding.
package uart_console_pkg;

    localparam logic [7:0] ASC_BS  = 8'h08;
    localparam logic [7:0] ASC_DEL = 8'h7F;
    localparam logic [7:0] ASC_ESC = 8'h1B;
    localparam logic [7:0] ASC_CR  = 8'h0D;
    localparam logic [7:0] ASC_LF  = 8'h0A;
    localparam logic [7:0] ASC_BEL = 8'h07;
    localparam logic [7:0] ASC_QM  = 8'h3F;

    typedef enum logic [2:0] {
        CLS_HEX,
        CLS_BS,
        CLS_ESC,
        CLS_ENTER,
        CLS_BAD
    } cls_t;

    typedef enum logic {
        ST_EMPTY,
        ST_ENTRY
    } entry_state_t;

endpackage

// File: rtl/ascii_hex_decode.sv
// Combinational classifier: maps a received byte to its editing class and,
// for hex digits of either case, to its 4-bit value.
module ascii_hex_decode
    import uart_console_pkg::*;
(
    input  logic [7:0] byte_in,
    output cls_t       byte_class,
    output logic [3:0] nib
);

    always_comb begin
        byte_class = CLS_BAD;
        nib        = 4'h0;
        if (byte_in >= 8'h30 && byte_in <= 8'h39) begin
            byte_class = CLS_HEX;
            nib        = byte_in[3:0];
        end else if ((byte_in >= 8'h61 && byte_in <= 8'h66) ||
                     (byte_in >= 8'h41 && byte_in <= 8'h46)) begin
            // Both letter ranges put 1..6 in the low nibble, so +9 gives A..F.
            byte_class = CLS_HEX;
            nib        = byte_in[3:0] + 4'd9;
        end else begin
            unique case (byte_in)
                ASC_BS, ASC_DEL: byte_class = CLS_BS;
                ASC_ESC:         byte_class = CLS_ESC;
                ASC_CR, ASC_LF:  byte_class = CLS_ENTER;
                default:         byte_class = CLS_BAD;
            endcase
        end
    end

endmodule

// File: rtl/uart_hex_entry.sv
// Terminal line editor: assembles hex digits from received bytes into a word,
// handles backspace/escape/enter and echoes each byte through a 1-deep slot.
module uart_hex_entry
    import uart_console_pkg::*;
#(
    parameter  int                 DIGITS     = 4,
    localparam int                 VALUE_W    = 4 * DIGITS,
    parameter  logic [VALUE_W-1:0] INIT_VALUE = 16'hAA00
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    input  logic               tx_ready,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    output logic [VALUE_W-1:0] value,
    output logic               value_valid,
    output logic [VALUE_W-1:0] digits,
    output logic [2:0]         count,
    output logic               err,
    output logic               overrun
);

    localparam logic [2:0] DIGITS_C = 3'(DIGITS);

    cls_t               byte_class;
    logic [3:0]         nib;
    logic               rx_edge;
    logic               tx_fire;
    logic               echo_en;
    logic [7:0]         echo_byte;
    entry_state_t       state;

    logic               rx_prev_q,     rx_prev_d;
    logic [2:0]         count_q,       count_d;
    logic [VALUE_W-1:0] digits_q,      digits_d;
    logic [VALUE_W-1:0] value_q,       value_d;
    logic               value_valid_q, value_valid_d;
    logic               err_q,         err_d;
    logic               overrun_q,     overrun_d;
    logic               tx_valid_q,    tx_valid_d;
    logic [7:0]         tx_data_q,     tx_data_d;

    ascii_hex_decode u_decode (
        .byte_in    (rx_data),
        .byte_class (byte_class),
        .nib        (nib)
    );

    assign rx_edge = rx_valid && !rx_prev_q;
    assign tx_fire = tx_valid_q && tx_ready;
    assign state   = (count_q == 3'd0) ? ST_EMPTY : ST_ENTRY;

    always_comb begin
        rx_prev_d     = rx_valid;
        count_d       = count_q;
        digits_d      = digits_q;
        value_d       = value_q;
        value_valid_d = 1'b0;
        err_d         = 1'b0;
        overrun_d     = 1'b0;
        tx_valid_d    = tx_valid_q;
        tx_data_d     = tx_data_q;
        echo_en       = 1'b0;
        echo_byte     = 8'h00;

        if (rx_edge) begin
            unique case (byte_class)
                CLS_HEX: begin
                    echo_en = 1'b1;
                    if (count_q < DIGITS_C) begin
                        digits_d  = VALUE_W'({digits_q, nib});
                        count_d   = count_q + 3'd1;
                        echo_byte = rx_data;
                    end else begin
                        err_d     = 1'b1;
                        echo_byte = ASC_BEL;
                    end
                end
                CLS_BS: begin
                    if (state == ST_ENTRY) begin
                        digits_d  = digits_q >> 4;
                        count_d   = count_q - 3'd1;
                        echo_en   = 1'b1;
                        echo_byte = ASC_BS;
                    end
                end
                CLS_ESC: begin
                    digits_d  = '0;
                    count_d   = 3'd0;
                    echo_en   = 1'b1;
                    echo_byte = ASC_ESC;
                end
                CLS_ENTER: begin
                    if (state == ST_ENTRY) begin
                        value_d       = digits_q;
                        value_valid_d = 1'b1;
                        digits_d      = '0;
                        count_d       = 3'd0;
                    end
                    echo_en   = 1'b1;
                    echo_byte = ASC_CR;
                end
                default: begin
                    err_d     = 1'b1;
                    echo_en   = 1'b1;
                    echo_byte = ASC_QM;
                end
            endcase
        end

        // A slot draining this cycle counts as free, so back-to-back echoes
        // never overrun while the sink keeps up.
        if (echo_en) begin
            if (!tx_valid_q || tx_fire) begin
                tx_valid_d = 1'b1;
                tx_data_d  = echo_byte;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (tx_fire) begin
            tx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_prev_q     <= 1'b0;
            count_q       <= 3'd0;
            digits_q      <= '0;
            value_q       <= INIT_VALUE;
            value_valid_q <= 1'b0;
            err_q         <= 1'b0;
            overrun_q     <= 1'b0;
            tx_valid_q    <= 1'b0;
            tx_data_q     <= 8'h00;
        end else begin
            rx_prev_q     <= rx_prev_d;
            count_q       <= count_d;
            digits_q      <= digits_d;
            value_q       <= value_d;
            value_valid_q <= value_valid_d;
            err_q         <= err_d;
            overrun_q     <= overrun_d;
            tx_valid_q    <= tx_valid_d;
            tx_data_q     <= tx_data_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign value       = value_q;
    assign value_valid = value_valid_q;
    assign digits      = digits_q;
    assign count       = count_q;
    assign err         = err_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_hex_entry.sv
// Self-checking bench for uart_hex_entry: directed scenarios followed by
// randomized traffic, all compared against a queue-based line-editor model.
module tb_uart_hex_entry;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic [15:0] value;
    logic        value_valid;
    logic [15:0] digits;
    logic [2:0]  count;
    logic        err;
    logic        overrun;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [3:0]  m_nibs[$];
    logic [15:0] m_value;
    logic        m_prev, m_vv, m_err, m_ovr, m_tx_valid;
    logic [7:0]  m_tx_data;

    uart_hex_entry #(.DIGITS(4), .INIT_VALUE(16'hAA00)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .value       (value),
        .value_valid (value_valid),
        .digits      (digits),
        .count       (count),
        .err         (err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    function automatic int hex_index(input logic [7:0] b);
        string      hexs;
        logic [7:0] lc;
        hexs = "0123456789abcdef";
        lc   = (b >= 8'h41 && b <= 8'h5A) ? b + 8'h20 : b;
        for (int i = 0; i < 16; i++)
            if (hexs[i] == lc) return i;
        return -1;
    endfunction

    function automatic logic [15:0] packed_nibs();
        logic [15:0] acc;
        acc = 16'h0;
        foreach (m_nibs[i]) acc = {acc[11:0], m_nibs[i]};
        return acc;
    endfunction

    task automatic model_reset();
        m_nibs.delete();
        m_value    = 16'hAA00;
        m_prev     = 1'b0;
        m_vv       = 1'b0;
        m_err      = 1'b0;
        m_ovr      = 1'b0;
        m_tx_valid = 1'b0;
        m_tx_data  = 8'h00;
    endtask

    task automatic model_step(input logic rxv, input logic [7:0] rxd, input logic rdy);
        logic       xfer;
        logic       have;
        logic [7:0] echo;
        int         h;
        xfer  = m_tx_valid && rdy;
        have  = 1'b0;
        echo  = 8'h00;
        m_vv  = 1'b0;
        m_err = 1'b0;
        m_ovr = 1'b0;
        if (rxv && !m_prev) begin
            h = hex_index(rxd);
            if (h >= 0) begin
                have = 1'b1;
                if (m_nibs.size() < 4) begin
                    m_nibs.push_back(4'(h));
                    echo = rxd;
                end else begin
                    m_err = 1'b1;
                    echo  = 8'h07;
                end
            end else if (rxd == 8'h08 || rxd == 8'h7F) begin
                if (m_nibs.size() > 0) begin
                    void'(m_nibs.pop_back());
                    have = 1'b1;
                    echo = 8'h08;
                end
            end else if (rxd == 8'h1B) begin
                m_nibs.delete();
                have = 1'b1;
                echo = 8'h1B;
            end else if (rxd == 8'h0D || rxd == 8'h0A) begin
                if (m_nibs.size() > 0) begin
                    m_value = packed_nibs();
                    m_vv    = 1'b1;
                    m_nibs.delete();
                end
                have = 1'b1;
                echo = 8'h0D;
            end else begin
                m_err = 1'b1;
                have  = 1'b1;
                echo  = 8'h3F;
            end
        end
        m_prev = rxv;
        if (have) begin
            if (!m_tx_valid || xfer) begin
                m_tx_valid = 1'b1;
                m_tx_data  = echo;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (xfer) begin
            m_tx_valid = 1'b0;
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        check_val({tag, ".value"},       32'(value),       32'(m_value));
        check_val({tag, ".value_valid"}, 32'(value_valid), 32'(m_vv));
        check_val({tag, ".digits"},      32'(digits),      32'(packed_nibs()));
        check_val({tag, ".count"},       32'(count),       32'(m_nibs.size()));
        check_val({tag, ".err"},         32'(err),         32'(m_err));
        check_val({tag, ".overrun"},     32'(overrun),     32'(m_ovr));
        check_val({tag, ".tx_valid"},    32'(tx_valid),    32'(m_tx_valid));
        if (m_tx_valid || tag == "reset")
            check_val({tag, ".tx_data"}, 32'(tx_data),     32'(m_tx_data));
    endtask

    // One clock cycle: drive at the negedge, model the posedge, check at the next negedge.
    task automatic applyStimulus(input logic rxv, input logic [7:0] rxd, input logic rdy, input string tag);
        rx_valid = rxv;
        rx_data  = rxd;
        tx_ready = rdy;
        @(posedge clk);
        model_step(rxv, rxd, rdy);
        @(negedge clk);
        checkOutput(tag);
    endtask

    task automatic press(input logic [7:0] b, input logic rdy);
        applyStimulus(1'b1, b, rdy, "press");
    endtask

    task automatic release_rx(input logic rdy);
        applyStimulus(1'b0, rx_data, rdy, "release");
    endtask

    task automatic send(input logic [7:0] b, input logic rdy);
        press(b, rdy);
        release_rx(rdy);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        model_reset();
        #2;
        checkOutput("reset");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("reset");
    endtask

    initial begin
        logic [7:0] pool[14];
        logic [7:0] rb;
        logic       rv, rr;

        pool = '{8'h30, 8'h39, 8'h61, 8'h66, 8'h41, 8'h46, 8'h67, 8'h47,
                 8'h08, 8'h7F, 8'h1B, 8'h0D, 8'h0A, 8'h20};
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        model_reset();
        @(negedge clk);
        checkOutput("reset");
        check_val("reset.value_const", 32'(value), 32'h0000AA00);
        rst_n = 1'b1;

        // 1: simple entry and commit with echo
        press(8'h31, 1); check_val("t1.echo1", 32'(tx_data), 32'h31); release_rx(1);
        press(8'h61, 1); check_val("t1.echo2", 32'(tx_data), 32'h61); release_rx(1);
        press(8'h46, 1); check_val("t1.echo3", 32'(tx_data), 32'h46); release_rx(1);
        press(8'h33, 1); check_val("t1.echo4", 32'(tx_data), 32'h33); release_rx(1);
        press(8'h0D, 1);
        check_val("t1.echo5", 32'(tx_data), 32'h0D);
        check_val("t1.value", 32'(value), 32'h1AF3);
        check_val("t1.vvalid", 32'(value_valid), 32'h1);
        release_rx(1);
        check_val("t1.vpulse", 32'(value_valid), 32'h0);

        // 2: overflow on a fifth digit
        send(8'h31, 1); send(8'h32, 1); send(8'h33, 1); send(8'h34, 1);
        check_val("t2.digits", 32'(digits), 32'h1234);
        check_val("t2.count", 32'(count), 32'd4);
        press(8'h35, 1);
        check_val("t2.err", 32'(err), 32'h1);
        check_val("t2.bel", 32'(tx_data), 32'h07);
        release_rx(1);
        send(8'h0D, 1);
        check_val("t2.value", 32'(value), 32'h1234);

        // 3: backspace editing and backspace on an empty line
        send(8'h41, 1); send(8'h42, 1); send(8'h08, 1); send(8'h43, 1); send(8'h0D, 1);
        check_val("t3.value", 32'(value), 32'h00AC);
        press(8'h7F, 1);
        check_val("t3.bs_noecho", 32'(tx_valid), 32'h0);
        check_val("t3.bs_noerr", 32'(err), 32'h0);
        release_rx(1);

        // 4: escape clears, empty enter keeps the value, bad byte rejected
        do_reset();
        send(8'h37, 1); send(8'h1B, 1);
        press(8'h0D, 1);
        check_val("t4.value", 32'(value), 32'hAA00);
        check_val("t4.novv", 32'(value_valid), 32'h0);
        release_rx(1);
        send(8'h39, 1);
        press(8'h47, 1);
        check_val("t4.err", 32'(err), 32'h1);
        check_val("t4.qm", 32'(tx_data), 32'h3F);
        check_val("t4.count", 32'(count), 32'd1);
        release_rx(1);
        send(8'h1B, 1);
        release_rx(1);

        // 5: sink stalled, echo overrun, then load while draining
        send(8'h31, 0);
        press(8'h32, 0);
        check_val("t5.ovr", 32'(overrun), 32'h1);
        check_val("t5.held", 32'(tx_data), 32'h31);
        release_rx(0);
        check_val("t5.digits", 32'(digits), 32'h0012);
        press(8'h33, 1);
        check_val("t5.load3", 32'(tx_data), 32'h33);
        check_val("t5.noovr", 32'(overrun), 32'h0);
        release_rx(1);

        // 6: long rx_valid is one byte; reset discards the partial line
        send(8'h1B, 1);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8'h35, 1'b1, "hold");
        check_val("t6.count", 32'(count), 32'd1);
        release_rx(1);
        send(8'h36, 1);
        do_reset();
        check_val("t6.value", 32'(value), 32'hAA00);
        check_val("t6.count0", 32'(count), 32'd0);
        check_val("t6.txv", 32'(tx_valid), 32'h0);

        // Random traffic; the byte only changes while rx_valid is low
        rb = 8'h30;
        for (int i = 0; i < 600; i++) begin
            rv = ($urandom_range(0, 9) < 5);
            rr = ($urandom_range(0, 9) < 6);
            if (!rx_valid)
                rb = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255))
                                                 : pool[$urandom_range(0, 13)];
            if ($urandom_range(0, 199) == 0) do_reset();
            else applyStimulus(rv, rb, rr, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
